// File: rtl/div_ctrl_if.sv
// Issue-side request/response bundle for the divide sequencer.
// The issue stage is the master, div_ctrl is the slave.
interface div_ctrl_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [2:0]  op_i;
   logic [63:0] op_1_i;
   logic [63:0] op_2_i;
   logic        flush_i;
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic [63:0] resp_data_o;
   logic        busy_o;

   modport master (
      output req_valid_i, op_i, op_1_i, op_2_i, flush_i, resp_ready_i,
      input  req_ready_o, resp_valid_o, resp_data_o, busy_o
   );

   modport slave (
      input  req_valid_i, op_i, op_1_i, op_2_i, flush_i, resp_ready_i,
      output req_ready_o, resp_valid_o, resp_data_o, busy_o
   );
endinterface

// File: rtl/div_ctrl.sv
// Sequencer for the iterative 64-bit divider: fast special cases,
// one-entry DIV/REM result cache, *W post-processing and flush drain.
module div_ctrl #(
   parameter bit CACHE_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   div_ctrl_if.slave   bus,
   output logic        div_req_valid_o,
   output logic [63:0] div_op_1_o,
   output logic [63:0] div_op_2_o,
   output logic        div_sign_op_1_o,
   output logic        div_sign_op_2_o,
   input  logic [63:0] div_quotient_i,
   input  logic [63:0] div_remainder_i,
   input  logic        div_valid_i
);

   typedef enum logic [2:0] {
      IDLE, ISSUE, WAIT, RESP, DRAIN
   } state_e;

   state_e      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [63:0] a_q, a_d;
   logic [63:0] b_q, b_d;
   logic [63:0] res_q, res_d;
   logic        cvld_q, cvld_d;
   logic [63:0] ca_q, ca_d;
   logic [63:0] cb_q, cb_d;
   logic [1:0]  cop_q, cop_d;
   logic [63:0] cq_q, cq_d;
   logic [63:0] cr_q, cr_d;

   logic        w, s, dz, ov, hit, accept;
   logic [63:0] sp_q, sp_r;

   // Select quotient/remainder, then apply the *W sign extension.
   function automatic logic [63:0] fmt(input logic [2:0] op,
                                       input logic [63:0] q,
                                       input logic [63:0] r);
      logic [63:0] v;
      v = op[1] ? r : q;
      if (op[2]) v = {{32{v[31]}}, v[31:0]};
      return v;
   endfunction

   always_comb begin
      w  = bus.op_i[2];
      s  = !bus.op_i[0];
      dz = w ? (bus.op_2_i[31:0] == 32'd0) : (bus.op_2_i == 64'd0);
      if (w)
         ov = s && (bus.op_1_i[31:0] == 32'h8000_0000)
                && (bus.op_2_i[31:0] == 32'hFFFF_FFFF);
      else
         ov = s && (bus.op_1_i == {1'b1, 63'd0})
                && (bus.op_2_i == {64{1'b1}});
      sp_q = dz ? {64{1'b1}} : bus.op_1_i;
      sp_r = dz ? bus.op_1_i : 64'd0;
      // op_i[1] is not part of the key so DIV and REM share an entry.
      hit = CACHE_EN && cvld_q
            && (bus.op_1_i == ca_q) && (bus.op_2_i == cb_q)
            && (bus.op_i[0] == cop_q[0]) && (bus.op_i[2] == cop_q[1]);
      accept = bus.req_valid_i && bus.req_ready_o;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cvld_q  <= 1'b0;
         ca_q    <= '0;
         cb_q    <= '0;
         cop_q   <= '0;
         cq_q    <= '0;
         cr_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cvld_q  <= cvld_d;
         ca_q    <= ca_d;
         cb_q    <= cb_d;
         cop_q   <= cop_d;
         cq_q    <= cq_d;
         cr_q    <= cr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:
            if (accept) state_d = (dz || ov || hit) ? RESP : ISSUE;
         ISSUE:
            state_d = bus.flush_i ? DRAIN : WAIT;
         WAIT:
            // A flush coinciding with completion has nothing left to drain.
            if (bus.flush_i) state_d = div_valid_i ? IDLE : DRAIN;
            else if (div_valid_i) state_d = RESP;
         RESP:
            if (bus.flush_i || bus.resp_ready_i) state_d = IDLE;
         DRAIN:
            if (div_valid_i) state_d = IDLE;
         default:
            state_d = IDLE;
      endcase
   end

   always_comb begin
      op_d   = op_q;
      a_d    = a_q;
      b_d    = b_q;
      res_d  = res_q;
      cvld_d = cvld_q;
      ca_d   = ca_q;
      cb_d   = cb_q;
      cop_d  = cop_q;
      cq_d   = cq_q;
      cr_d   = cr_q;
      if (state_q == IDLE && accept) begin
         op_d = bus.op_i;
         a_d  = bus.op_1_i;
         b_d  = bus.op_2_i;
         if (dz || ov) res_d = fmt(bus.op_i, sp_q, sp_r);
         else if (hit) res_d = fmt(bus.op_i, cq_q, cr_q);
      end
      if (state_q == WAIT && div_valid_i && !bus.flush_i) begin
         res_d  = fmt(op_q, div_quotient_i, div_remainder_i);
         cvld_d = CACHE_EN;
         ca_d   = a_q;
         cb_d   = b_q;
         cop_d  = {op_q[2], op_q[0]};
         cq_d   = div_quotient_i;
         cr_d   = div_remainder_i;
      end
   end

   always_comb begin
      bus.req_ready_o  = (state_q == IDLE) && !bus.flush_i;
      bus.resp_valid_o = (state_q == RESP);
      bus.resp_data_o  = res_q;
      bus.busy_o       = (state_q != IDLE);
      div_req_valid_o  = (state_q == ISSUE);
      div_sign_op_1_o  = !op_q[0];
      div_sign_op_2_o  = !op_q[0];
      if (!op_q[2]) begin
         div_op_1_o = a_q;
         div_op_2_o = b_q;
      end else if (!op_q[0]) begin
         div_op_1_o = {{32{a_q[31]}}, a_q[31:0]};
         div_op_2_o = {{32{b_q[31]}}, b_q[31:0]};
      end else begin
         div_op_1_o = {32'd0, a_q[31:0]};
         div_op_2_o = {32'd0, b_q[31:0]};
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a 66-cycle behavioural divider model.
// Expected results are hand-computed constants.
module tb_div_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        div_req_valid_o;
   logic [63:0] div_op_1_o, div_op_2_o;
   logic        div_sign_op_1_o, div_sign_op_2_o;
   logic [63:0] div_quotient_i, div_remainder_i;
   logic        div_valid_i;

   int passed = 0;
   int total  = 0;
   int n_issue;
   int cnt;

   div_ctrl_if bus ();

   div_ctrl #(.CACHE_EN(1'b1)) dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus),
      .div_req_valid_o (div_req_valid_o),
      .div_op_1_o      (div_op_1_o),
      .div_op_2_o      (div_op_2_o),
      .div_sign_op_1_o (div_sign_op_1_o),
      .div_sign_op_2_o (div_sign_op_2_o),
      .div_quotient_i  (div_quotient_i),
      .div_remainder_i (div_remainder_i),
      .div_valid_i     (div_valid_i)
   );

   always #5 clk = ~clk;

   // Divider model: valid_o 66 cycles after the accepted request.
   always @(posedge clk) begin
      if (rst) begin
         cnt     <= 0;
         n_issue <= 0;
      end else if (div_req_valid_o) begin
         cnt     <= 66;
         n_issue <= n_issue + 1;
         if (div_sign_op_1_o) begin
            div_quotient_i  <= $signed(div_op_1_o) / $signed(div_op_2_o);
            div_remainder_i <= $signed(div_op_1_o) % $signed(div_op_2_o);
         end else begin
            div_quotient_i  <= div_op_1_o / div_op_2_o;
            div_remainder_i <= div_op_1_o % div_op_2_o;
         end
      end else if (cnt != 0) begin
         cnt <= cnt - 1;
      end
   end
   assign div_valid_i = (cnt == 1);

   task automatic do_req(input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, output int lat,
                         output logic [63:0] data, output logic [63:0] d1,
                         output logic [63:0] d2, output logic sg);
      bus.req_valid_i = 1'b1;
      bus.op_i   = op;
      bus.op_1_i = a;
      bus.op_2_i = b;
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      d1  = div_op_1_o;
      d2  = div_op_2_o;
      sg  = div_sign_op_1_o | div_sign_op_2_o;
      lat = 1;
      while (!bus.resp_valid_o && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      data = bus.resp_data_o;
   endtask

   task automatic consume();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_valid_i  = 1'b1;
      bus.op_i         = 3'b000;
      bus.op_1_i       = 64'd5;
      bus.op_2_i       = 64'd0;
      bus.flush_i      = 1'b0;
      bus.resp_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (bus.resp_valid_o !== 1'b0 || bus.busy_o !== 1'b0 ||
          div_req_valid_o !== 1'b0 || bus.resp_data_o !== 64'd0) begin
         $display("FAIL reset: valid=%b busy=%b dreq=%b data=%h want 0 0 0 0",
                  bus.resp_valid_o, bus.busy_o, div_req_valid_o,
                  bus.resp_data_o);
      end else passed++;
      bus.req_valid_i = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      total++;
      if (bus.req_ready_o !== 1'b1 || bus.busy_o !== 1'b0)
         $display("FAIL reset_idle: ready=%b busy=%b want 1 0",
                  bus.req_ready_o, bus.busy_o);
      else passed++;
   endtask

   task automatic test_div_path();
      int lat, i0;
      logic [63:0] d, d1, d2;
      logic sg;
      i0 = n_issue;
      do_req(3'b000, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, lat, d, d1, d2, sg);
      total++;
      if (lat !== 68 || d !== 64'hFFFF_FFFF_FFFF_FFF2)
         $display("FAIL div_100_m7: lat=%0d data=%h want 68 fffffffffffffff2",
                  lat, d);
      else passed++;
      total++;
      if (n_issue - i0 !== 1)
         $display("FAIL div_issue_once: got %0d want 1", n_issue - i0);
      else passed++;
      consume();
   endtask

   task automatic test_cache_hit();
      int lat, i0;
      logic [63:0] d, d1, d2;
      logic sg;
      i0 = n_issue;
      do_req(3'b010, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, lat, d, d1, d2, sg);
      total++;
      if (lat !== 1 || d !== 64'd2 || n_issue != i0)
         $display("FAIL rem_hit: lat=%0d data=%h issues=%0d want 1 2 0",
                  lat, d, n_issue - i0);
      else passed++;
      consume();
   endtask

   task automatic test_div_zero();
      int lat, i0;
      logic [63:0] d, d1, d2;
      logic sg;
      i0 = n_issue;
      do_req(3'b001, 64'h1234, 64'd0, lat, d, d1, d2, sg);
      total++;
      if (lat !== 1 || d !== 64'hFFFF_FFFF_FFFF_FFFF)
         $display("FAIL divu_zero: lat=%0d data=%h want 1 ffffffffffffffff",
                  lat, d);
      else passed++;
      consume();
      do_req(3'b110, 64'h0000_0001_8000_0005, 64'd0, lat, d, d1, d2, sg);
      total++;
      if (lat !== 1 || d !== 64'hFFFF_FFFF_8000_0005)
         $display("FAIL remw_zero: lat=%0d data=%h want 1 ffffffff80000005",
                  lat, d);
      else passed++;
      consume();
      total++;
      if (n_issue != i0)
         $display("FAIL dz_no_issue: got %0d want 0", n_issue - i0);
      else passed++;
   endtask

   task automatic test_overflow();
      int lat, i0;
      logic [63:0] d, d1, d2;
      logic sg;
      i0 = n_issue;
      do_req(3'b000, 64'h8000_0000_0000_0000, '1, lat, d, d1, d2, sg);
      total++;
      if (lat !== 1 || d !== 64'h8000_0000_0000_0000)
         $display("FAIL div_ovf: lat=%0d data=%h want 1 8000000000000000",
                  lat, d);
      else passed++;
      consume();
      do_req(3'b100, 64'h8000_0000, 64'hFFFF_FFFF, lat, d, d1, d2, sg);
      total++;
      if (lat !== 1 || d !== 64'hFFFF_FFFF_8000_0000)
         $display("FAIL divw_ovf: lat=%0d data=%h want 1 ffffffff80000000",
                  lat, d);
      else passed++;
      consume();
      do_req(3'b010, 64'h8000_0000_0000_0000, '1, lat, d, d1, d2, sg);
      total++;
      if (lat !== 1 || d !== 64'd0 || n_issue != i0)
         $display("FAIL rem_ovf: lat=%0d data=%h issues=%0d want 1 0 0",
                  lat, d, n_issue - i0);
      else passed++;
      consume();
   endtask

   task automatic test_divuw();
      int lat;
      logic [63:0] d, d1, d2;
      logic sg;
      do_req(3'b101, 64'hFFFF_FFFF, 64'd1, lat, d, d1, d2, sg);
      total++;
      if (d1 !== 64'h0000_0000_FFFF_FFFF || d2 !== 64'd1 || sg !== 1'b0)
         $display("FAIL divuw_ops: op1=%h op2=%h sign=%b want ffffffff 1 0",
                  d1, d2, sg);
      else passed++;
      total++;
      if (lat !== 68 || d !== 64'hFFFF_FFFF_FFFF_FFFF)
         $display("FAIL divuw_res: lat=%0d data=%h want 68 ffffffffffffffff",
                  lat, d);
      else passed++;
      consume();
   endtask

   task automatic test_flush();
      int k;
      logic seen_resp, lost_busy;
      bus.req_valid_i = 1'b1;
      bus.op_i   = 3'b000;
      bus.op_1_i = 64'd7;
      bus.op_2_i = 64'd2;
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      k = 11;
      seen_resp = 1'b0;
      lost_busy = 1'b0;
      while (!bus.req_ready_o && k < 200) begin
         if (bus.resp_valid_o) seen_resp = 1'b1;
         if (!bus.busy_o) lost_busy = 1'b1;
         @(posedge clk); #1;
         k++;
      end
      total++;
      if (k !== 68 || seen_resp || lost_busy)
         $display("FAIL flush_drain: ready_at=%0d resp=%b nobusy=%b want 68 0 0",
                  k, seen_resp, lost_busy);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int lat, i0;
      logic [63:0] d, d1, d2;
      logic sg;
      logic stable;
      i0 = n_issue;
      bus.resp_ready_i = 1'b0;
      do_req(3'b000, 64'd7, 64'd2, lat, d, d1, d2, sg);
      total++;
      if (lat !== 68 || d !== 64'd3 || n_issue - i0 !== 1)
         $display("FAIL reissue: lat=%0d data=%h issues=%0d want 68 3 1",
                  lat, d, n_issue - i0);
      else passed++;
      stable = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== 64'd3)
            stable = 1'b0;
      end
      total++;
      if (!stable)
         $display("FAIL backpressure: valid=%b data=%h want 1 3",
                  bus.resp_valid_o, bus.resp_data_o);
      else passed++;
      bus.resp_ready_i = 1'b1;
      @(posedge clk); #1;
      total++;
      if (bus.resp_valid_o !== 1'b0 || bus.busy_o !== 1'b0 ||
          bus.req_ready_o !== 1'b1)
         $display("FAIL resp_done: valid=%b busy=%b ready=%b want 0 0 1",
                  bus.resp_valid_o, bus.busy_o, bus.req_ready_o);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_div_path();
      test_cache_hit();
      test_div_zero();
      test_overflow();
      test_divuw();
      test_flush();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
